// File: rtl/store_serializer_if.sv
// Load-side handshake between the arithmetic unit and the store serializer.
interface store_serializer_if;
  logic [34:0] word_in;
  logic        long_in;
  logic        load_valid;
  logic        load_ready;

  modport master (
    output word_in,
    output long_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  word_in,
    input  long_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/store_serializer.sv
// Parallel-to-serial word transmitter for the store write path, LSB-first, aligned to c1.
// Define STORE_SERIALIZER_LONG_EN to enable 35-bit long words; otherwise every word is 17 bits.
module store_serializer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c1,
  store_serializer_if.slave bus,
  output logic              mib,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

`ifdef STORE_SERIALIZER_LONG_EN
  localparam int unsigned SregW = 35;
`else
  localparam int unsigned SregW = 17;
`endif
  localparam logic [5:0] ShortLen = 6'd17;
  localparam logic [5:0] LongLen  = 6'd35;

  typedef enum logic [1:0] {StIdle, StArmed, StShift} state_e;

  state_e           state_q, state_d;
  logic [SregW-1:0] sreg_q, sreg_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             mib_q, mib_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;

  logic [SregW-1:0] load_word;
  logic [5:0]       load_len;

`ifdef STORE_SERIALIZER_LONG_EN
  assign load_word = bus.long_in ? bus.word_in : {18'd0, bus.word_in[16:0]};
  assign load_len  = bus.long_in ? LongLen : ShortLen;
`else
  // Length flag and upper word bits have no effect in the short-only build.
  logic unused_long;
  assign unused_long = ^{bus.long_in, bus.word_in[34:17]};
  assign load_word   = bus.word_in[16:0];
  assign load_len    = ShortLen;
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mib_d   = 1'b0;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          sreg_d  = load_word;
          cnt_d   = load_len;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (c1) begin
          mib_d   = sreg_q[0];
          wr_en_d = 1'b1;
          sreg_d  = sreg_q >> 1;
          cnt_d   = cnt_q - 6'd1;
          state_d = StShift;
        end
      end
      StShift: begin
        // cnt_q counts bits still to present; zero means the last one is on mib now.
        if (cnt_q != 6'd0) begin
          mib_d   = sreg_q[0];
          wr_en_d = 1'b1;
          sreg_d  = sreg_q >> 1;
          cnt_d   = cnt_q - 6'd1;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mib_q   <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mib_q   <= mib_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

  assign mib            = mib_q;
  assign wr_en          = wr_en_q;
  assign done           = done_q;
  assign busy           = (state_q != StIdle);
  assign bus.load_ready = (state_q == StIdle);

endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench for store_serializer: scenario tasks plus randomized traffic
// checked every cycle against a timeline model of the serial word transfer.
`timescale 1ns/1ps
module tb_store_serializer;
  localparam int Ph = 5;  // cycle index (mod 18) on which c1 is high
`ifdef STORE_SERIALIZER_LONG_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic c1 = 1'b0;
  logic mib, wr_en, busy, done;

  store_serializer_if bus ();

  store_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c1    (c1),
    .bus   (bus),
    .mib   (mib),
    .wr_en (wr_en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: one word in flight, described by capture cycle, first-bit cycle and length.
  bit          m_valid = 1'b0;
  int          m_tc, m_first, m_len;
  logic [34:0] m_word;

  function automatic int next_c1(int t);
    return t + 1 + ((Ph - ((t + 1) % 18) + 18) % 18);
  endfunction

  function automatic bit m_busy(int t);
    return m_valid && (t > m_tc) && (t < m_first + m_len);
  endfunction

  // Expected {mib, wr_en, done, busy, load_ready} in cycle t.
  function automatic logic [4:0] exp_vec(int t);
    logic wr, mb, dn, bz;
    wr = m_valid && (t >= m_first) && (t < m_first + m_len);
    mb = wr ? m_word[t - m_first] : 1'b0;
    dn = m_valid && (t == m_first + m_len);
    bz = m_busy(t);
    return {mb, wr, dn, bz, !bz};
  endfunction

  function automatic logic [4:0] obs();
    return {mib, wr_en, done, busy, bus.load_ready};
  endfunction

  // Apply current inputs across one clock edge, update the model, sample after the edge.
  task automatic tick();
    c1 = ((cyc % 18) == Ph);
    if (!rst_n) begin
      m_valid = 1'b0;
    end else if (bus.load_valid && !m_busy(cyc)) begin
      m_valid = 1'b1;
      m_tc    = cyc;
      m_first = next_c1(cyc) + 1;
      m_len   = (LongEn && bus.long_in) ? 35 : 17;
      m_word  = bus.word_in;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    bus.load_valid = 1'b0;
    bus.long_in    = 1'b0;
    bus.word_in    = '0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs() !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=%b", obs(), 5'b00001);
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
    end
  endtask

  task automatic test_short_word();
    logic [16:0] want = 17'h0A5A5;
    logic [16:0] bits = '0;
    int nb = 0, first_wr = -1, done_at = -1, n0;
    while (((cyc + 3) % 18) != Ph) tick();
    n0 = cyc + 3;
    bus.word_in    = 35'h0_0000_A5A5;
    bus.long_in    = 1'b0;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    repeat (26) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL short_word cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      if (wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = cyc;
        if (nb < 17) bits[nb] = mib;
        nb++;
      end
      if (done === 1'b1) done_at = cyc;
      tick();
    end
    n_cmp++;
    if (bits !== want || nb != 17) begin
      n_bad++;
      $display("FAIL short_bits got=%h/%0d want=%h/17", bits, nb, want);
    end
    n_cmp++;
    if (first_wr != n0 + 1 || done_at != n0 + 18) begin
      n_bad++;
      $display("FAIL short_timing first=%0d done=%0d want %0d/%0d", first_wr, done_at, n0 + 1,
               n0 + 18);
    end
  endtask

`ifdef STORE_SERIALIZER_LONG_EN
  task automatic test_long_word();
    logic [34:0] want = 35'h4_0000_0001;
    logic [34:0] bits = '0;
    int nb = 0, done_at = -1, n0;
    n0 = next_c1(cyc);
    bus.word_in    = want;
    bus.long_in    = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.long_in    = 1'b0;
    repeat (60) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL long_word cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      if (wr_en === 1'b1) begin
        if (nb < 35) bits[nb] = mib;
        nb++;
      end
      if (done === 1'b1) done_at = cyc;
      tick();
    end
    n_cmp++;
    if (bits !== want || nb != 35 || done_at != n0 + 36) begin
      n_bad++;
      $display("FAIL long_bits got=%h/%0d done=%0d want=%h/35 done=%0d", bits, nb, done_at, want,
               n0 + 36);
    end
  endtask
`else
  task automatic test_long_ignored();
    int ones = 0, nb = 0, done_at = -1, n0;
    n0 = next_c1(cyc);
    bus.word_in    = 35'h7_FFFF_FFFF;
    bus.long_in    = 1'b1;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.long_in    = 1'b0;
    repeat (60) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL long_ignored cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      if (wr_en === 1'b1) begin
        nb++;
        if (mib === 1'b1) ones++;
      end
      if (done === 1'b1) done_at = cyc;
      tick();
    end
    n_cmp++;
    if (ones != 17 || nb != 17 || done_at != n0 + 18) begin
      n_bad++;
      $display("FAIL long_ignored_count ones=%0d bits=%0d done=%0d want 17/17/%0d", ones, nb,
               done_at, n0 + 18);
    end
  endtask
`endif

  task automatic test_coincident_c1();
    int first_wr = -1, tl;
    while ((cyc % 18) != Ph) tick();
    tl = cyc;
    bus.word_in    = 35'h0_0001_3C3C;
    bus.long_in    = 1'b0;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    repeat (45) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL coincident cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      if (wr_en === 1'b1 && first_wr < 0) first_wr = cyc;
      tick();
    end
    n_cmp++;
    if (first_wr != tl + 19) begin
      n_bad++;
      $display("FAIL coincident_start got=%0d want=%0d", first_wr, tl + 19);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] wa, wb;
    logic [16:0] bits = '0;
    int nb = 0, d1 = -1, first_b = -1;
    wa = 17'($urandom);
    wb = ~wa;
    bus.word_in    = {18'd0, wa};
    bus.long_in    = 1'b0;
    bus.load_valid = 1'b1;
    tick();
    bus.word_in = {18'h3FFFF, wb};
    repeat (80) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      if (done === 1'b1 && d1 < 0) d1 = cyc;
      if (wr_en === 1'b1 && d1 >= 0 && cyc > d1) begin
        if (first_b < 0) first_b = cyc;
        if (nb < 17) bits[nb] = mib;
        nb++;
      end
      tick();
      if (d1 >= 0) bus.load_valid = 1'b0;
    end
    n_cmp++;
    if (d1 < 0 || first_b != d1 + 19 || bits !== wb || nb != 17) begin
      n_bad++;
      $display("FAIL back_to_back_second done=%0d first=%0d bits=%h/%0d want first=%0d bits=%h",
               d1, first_b, bits, nb, d1 + 19, wb);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bus.word_in    = {18'd0, 17'h1FFFF};
    bus.long_in    = 1'b0;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    while (cyc != m_first + 9 && guard < 60) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 60 || obs() !== exp_vec(cyc)) begin
      n_bad++;
      $display("FAIL reset_mid_bit9 cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_mid_async got=%b want=%b", obs(), 5'b00001);
    end
    tick();
    rst_n = 1'b1;
    repeat (30) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL reset_mid_after cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    repeat (900) begin
      n_cmp++;
      if (obs() !== exp_vec(cyc)) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs(), exp_vec(cyc));
      end
      r = {$urandom(), $urandom()};
      bus.word_in    = r[34:0];
      bus.long_in    = r[40];
      bus.load_valid = ($urandom_range(0, 3) == 0);
      rst_n          = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n          = 1'b1;
    bus.load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short_word();
`ifdef STORE_SERIALIZER_LONG_EN
    test_long_word();
`else
    test_long_ignored();
`endif
    test_coincident_c1();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
